// File: rtl/signed_sum_tube_display.sv
// Signed 3-bit adder driving a sign digit and a magnitude digit.
// One registered output stage between switches and display tubes.
module signed_sum_tube_display (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       tub_sflag_sel,
  output logic       tub_sabsolut_sel,
  output logic [7:0] tub_sflag_control,
  output logic [7:0] tub_sabsolut_control
);

  logic [3:0] sum;
  logic       neg;
  logic [3:0] mag;
  logic [7:0] mag_seg;
  logic [7:0] sign_seg;

  assign sum = {a[2], a} + {b[2], b};
  assign neg = sum[3];
  // -8 negates to 4'b1000, which reads as unsigned 8
  assign mag = neg ? (~sum + 4'd1) : sum;

  always_comb begin
    mag_seg = 8'h00;
    case (mag)
      4'd0:    mag_seg = 8'hFC;
      4'd1:    mag_seg = 8'h60;
      4'd2:    mag_seg = 8'hDA;
      4'd3:    mag_seg = 8'hF2;
      4'd4:    mag_seg = 8'h66;
      4'd5:    mag_seg = 8'hB6;
      4'd6:    mag_seg = 8'hBE;
      4'd7:    mag_seg = 8'hE0;
      4'd8:    mag_seg = 8'hFE;
      default: mag_seg = 8'h00;
    endcase
  end

  always_comb begin
    sign_seg = 8'h00;
    unique case (1'b1)
      neg:     sign_seg = 8'h02;
      default: sign_seg = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tub_sflag_sel        <= 1'b0;
      tub_sabsolut_sel     <= 1'b0;
      tub_sflag_control    <= 8'h00;
      tub_sabsolut_control <= 8'h00;
    end else begin
      tub_sflag_sel        <= 1'b1;
      tub_sabsolut_sel     <= 1'b1;
      tub_sflag_control    <= sign_seg;
      tub_sabsolut_control <= mag_seg;
    end
  end

endmodule

// File: tb/tb_signed_sum_tube_display.sv
// Directed and sweep bench for signed_sum_tube_display.
// Outputs sampled 1ns after the rising edge.
module tb_signed_sum_tube_display;

  logic       clk;
  logic       rst;
  logic [2:0] a;
  logic [2:0] b;
  logic       sflag_sel;
  logic       sabs_sel;
  logic [7:0] sflag_ctl;
  logic [7:0] sabs_ctl;

  int n_chk;
  int n_pass;

  localparam logic [7:0] PAT [9] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
    8'hB6, 8'hBE, 8'hE0, 8'hFE
  };

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] sflag;
    logic [7:0] sabs;
  } vec_t;

  vec_t vecs [5];

  signed_sum_tube_display dut (
    .clk                  (clk),
    .rst                  (rst),
    .a                    (a),
    .b                    (b),
    .tub_sflag_sel        (sflag_sel),
    .tub_sabsolut_sel     (sabs_sel),
    .tub_sflag_control    (sflag_ctl),
    .tub_sabsolut_control (sabs_ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic chk_all(
    input string      tag,
    input logic       sel,
    input logic [7:0] sflag,
    input logic [7:0] sabs
  );
    chk({tag, ".fsel"}, {7'd0, sflag_sel}, {7'd0, sel});
    chk({tag, ".asel"}, {7'd0, sabs_sel}, {7'd0, sel});
    chk({tag, ".sflag"}, sflag_ctl, sflag);
    chk({tag, ".sabs"}, sabs_ctl, sabs);
  endtask

  task automatic apply(input logic [2:0] va, input logic [2:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int m;
    n_chk  = 0;
    n_pass = 0;
    rst = 1'b1;
    a = 3'b010;
    b = 3'b101;

    vecs[0] = '{3'b000, 3'b000, 8'h00, 8'hFC};
    vecs[1] = '{3'b011, 3'b011, 8'h00, 8'hBE};
    vecs[2] = '{3'b100, 3'b100, 8'h02, 8'hFE};
    vecs[3] = '{3'b001, 3'b101, 8'h02, 8'hDA};
    vecs[4] = '{3'b111, 3'b001, 8'h00, 8'hFC};

    #12;
    chk_all("reset", 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    chk_all("reset_held", 1'b0, 8'h00, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    a = 3'b000;
    b = 3'b000;

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b);
      chk_all($sformatf("dir%0d", i), 1'b1,
              vecs[i].sflag, vecs[i].sabs);
    end

    for (int i = 0; i < 64; i++) begin
      logic [5:0] ab;
      ab = 6'(i);
      apply(ab[5:3], ab[2:0]);
      s = int'($signed(ab[5:3])) + int'($signed(ab[2:0]));
      m = (s < 0) ? -s : s;
      chk_all($sformatf("sweep_a%0d_b%0d",
                        $signed(ab[5:3]), $signed(ab[2:0])),
              1'b1, (s < 0) ? 8'h02 : 8'h00, PAT[m]);
    end

    // -3 + -2 = -5, reset pulse entirely between edges
    @(negedge clk);
    a = 3'b101;
    b = 3'b110;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 8'h00, 8'h00);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rst_release", 1'b1, 8'h02, 8'hB6);

    apply(3'b011, 3'b100);
    chk_all("after_rst", 1'b1, 8'h02, 8'h60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/signed_sum_tube_display.md
Name: signed_sum_tube_display

Overview:
- Adds two 3-bit two's-complement operands and drives two seven-segment digits from the result.
- One digit is the sign digit: it shows a minus sign for a negative result and is blank otherwise.
- The other digit is the magnitude digit: it shows the absolute value of the sum as a decimal digit 0..8.
- Sits between board switches and the display tubes. One registered output stage.

Parameters:
- None. Operand widths (3), segment width (8) and segment encoding are fixed.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous reset, active-high
- a  input  3  operand A, signed two's complement, range -4..3
- b  input  3  operand B, signed two's complement, range -4..3
- tub_sflag_sel  output  1  enable for the sign digit, active-high
- tub_sabsolut_sel  output  1  enable for the magnitude digit, active-high
- tub_sflag_control  output  8  segment pattern for the sign digit
- tub_sabsolut_control  output  8  segment pattern for the magnitude digit

Behaviour:
- Reset: while rst=1, all four outputs are held at 0, asynchronously. This includes both sel bits and both 8-bit controls (display dark).
- After reset: the two sel outputs become 1 on the first rising clk edge with rst=0, and stay 1.
- Arithmetic:
  - sum = sext(a) + sext(b), computed in 4-bit signed arithmetic.
  - Range is -8..6, so no overflow is possible.
  - neg = sum[3].
  - mag = neg ? -sum : sum, computed as a 4-bit unsigned value in the range 0..8.
- Latency:
  - Combinational decode feeds registers; outputs reflect the a/b values sampled at a rising clk edge.
  - Outputs are valid immediately after that edge (1-cycle latency).
  - No handshake; a and b are sampled every cycle.
- Segment encoding:
  - Bit layout is control[7:0] = {A,B,C,D,E,F,G,DP}, active-high.
  - DP is always 0.
- Magnitude digit patterns: 0=8'hFC, 1=8'h60, 2=8'hDA, 3=8'hF2, 4=8'h66, 5=8'hB6, 6=8'hBE, 7=8'hE0, 8=8'hFE.
  - mag values 9..15 cannot occur; if decoded, they produce 8'h00 (blank).
- Sign digit patterns:
  - neg=1: 8'h02 (segment G only, minus sign).
  - neg=0: 8'h00 (blank).
  - A zero result is never shown as negative.
- Boundaries:
  - Most-negative case: a=b=-4 gives sum -8, shown as minus and "8".
  - Maximum case: a=b=3 gives 6.
  - Opposite operands, e.g. a=-1 and b=1, give 0 with a blank sign digit.
- Reset mid-operation: outputs clear immediately when rst asserts. On release, normal operation resumes at the next clk edge using the current a/b.
- No other state: the block is a pure registered function of (a, b).

Test Plan:
- rst=1 with any a/b -> all outputs 0. Release rst, a=0, b=0, one edge -> sels=1, sflag=8'h00, sabsolut=8'hFC.
- a=3'b011 (3), b=3'b011 (3) -> after 1 edge: sflag=8'h00, sabsolut=8'hBE (6).
- a=3'b100 (-4), b=3'b100 (-4) -> sflag=8'h02, sabsolut=8'hFE (8).
- a=3'b001 (1), b=3'b101 (-3) -> sflag=8'h02, sabsolut=8'hDA (2). Then a=3'b111 (-1), b=3'b001 (1) -> sflag=8'h00, sabsolut=8'hFC.
- Exhaustive sweep of all 64 {a,b} combinations, one per clock -> each output matches the reference model (sign/abs of the 4-bit sum) exactly one cycle after the stimulus.
- Assert rst asynchronously mid-sweep between edges -> outputs drop to 0 without waiting for a clk edge. Deassert -> correct values on the next edge.
